// File: rtl/cam_reg_init.sv
// rtl/cam_reg_init.sv - camera register-initialisation sequencer
//
// Walks a fixed (register, value) table after reset and issues one write
// command per entry to the SCCB write master. An entry whose register is
// 0xFF is a settling delay, not a write. A NACKed write is reissued up to
// MAX_RETRY times before the sequencer gives up.
//
// Ports:
//   clk        system clock (40 MHz)
//   resetn     synchronous active-low reset
//   cmd_valid  write command presented to the SCCB master
//   cmd_ready  SCCB master accepts the command
//   cmd_reg    target register address
//   cmd_data   value to write
//   rsp_valid  one-cycle pulse when the SCCB transaction finishes
//   rsp_nack   qualified by rsp_valid, 1 = slave NACKed
//   init_done  sticky, whole table written
//   init_error sticky, an entry ran out of retries
//   cur_index  table index being processed

module cam_reg_init #(
    parameter int NUM_REGS     = 6,
    parameter int DELAY_CYCLES = 40000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_reg,
    output logic [7:0] cmd_data,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    output logic       init_done,
    output logic       init_error,
    output logic [7:0] cur_index
);

    // Counter only ever holds DELAY_CYCLES-1 down to 0.
    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [DW-1:0] DELAY_LOAD   = DW'(DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);
    localparam logic [7:0]    LAST_INDEX   = 8'(NUM_REGS - 1);
    localparam logic [7:0]    DELAY_MARKER = 8'hFF;

    typedef enum logic [2:0] {
        S_LOAD,
        S_SEND,
        S_WAIT_RSP,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      index_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [DW-1:0]   delay_q, delay_d;
    logic            valid_d;
    logic [7:0]      reg_d, data_d;
    logic            done_d, error_d;
    logic            advance;
    logic [7:0]      tbl_reg, tbl_data;

    // Initialisation table. Indices past the populated entries read as delay
    // markers so a larger NUM_REGS never issues writes to register 0.
    always_comb begin
        tbl_reg  = DELAY_MARKER;
        tbl_data = 8'h00;
        case (cur_index)
            8'd0: begin tbl_reg = 8'h12; tbl_data = 8'h80; end
            8'd1: begin tbl_reg = 8'hFF; tbl_data = 8'h00; end
            8'd2: begin tbl_reg = 8'h12; tbl_data = 8'h04; end
            8'd3: begin tbl_reg = 8'h11; tbl_data = 8'h01; end
            8'd4: begin tbl_reg = 8'h40; tbl_data = 8'hD0; end
            8'd5: begin tbl_reg = 8'h3A; tbl_data = 8'h04; end
            default: begin end
        endcase
    end

    always_comb begin
        state_d = state_q;
        index_d = cur_index;
        retry_d = retry_q;
        delay_d = delay_q;
        valid_d = cmd_valid;
        reg_d   = cmd_reg;
        data_d  = cmd_data;
        done_d  = init_done;
        error_d = init_error;
        advance = 1'b0;

        case (state_q)
            S_LOAD: begin
                reg_d  = tbl_reg;
                data_d = tbl_data;
                if (tbl_reg == DELAY_MARKER) begin
                    delay_d = DELAY_LOAD;
                    state_d = S_DELAY;
                end else begin
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (cmd_valid && cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (rsp_valid) begin
                    if (!rsp_nack) begin
                        retry_d = '0;
                        advance = 1'b1;
                    end else if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end
                end
            end
            S_DELAY: begin
                if (delay_q == '0) begin
                    advance = 1'b1;
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end
            S_DONE, S_ERROR: begin end
            default: state_d = S_LOAD;
        endcase

        // Shared by a successful write and an expired delay.
        if (advance) begin
            if (cur_index == LAST_INDEX) begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end else begin
                index_d = cur_index + 8'd1;
                state_d = S_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_LOAD;
            cur_index  <= 8'd0;
            retry_q    <= '0;
            delay_q    <= '0;
            cmd_valid  <= 1'b0;
            cmd_reg    <= 8'd0;
            cmd_data   <= 8'd0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_index  <= index_d;
            retry_q    <= retry_d;
            delay_q    <= delay_d;
            cmd_valid  <= valid_d;
            cmd_reg    <= reg_d;
            cmd_data   <= data_d;
            init_done  <= done_d;
            init_error <= error_d;
        end
    end

endmodule

// File: tb/tb_cam_reg_init.sv
// tb/tb_cam_reg_init.sv - scoreboard bench for cam_reg_init

module tb_cam_reg_init;

    logic       clk;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_nack;
    logic       init_done;
    logic       init_error;
    logic [7:0] cur_index;

    cam_reg_init #(
        .NUM_REGS    (6),
        .DELAY_CYCLES(10),
        .MAX_RETRY   (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_nack  (rsp_nack),
        .init_done (init_done),
        .init_error(init_error),
        .cur_index (cur_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          passed = 0;
    int          total  = 0;
    logic [15:0] exp_q[$];
    int          gaps[$];
    int          nack_left[8];
    int          xfer_cnt[8];
    int          stall_idx;
    int          stall_left;
    bit          reset_in_stall;
    bit          spurious;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] d);
        exp_q.push_back({r, d});
    endtask

    task automatic push_full();
        push(8'h12, 8'h80);
        push(8'h12, 8'h04);
        push(8'h11, 8'h01);
        push(8'h40, 8'hD0);
        push(8'h3A, 8'h04);
    endtask

    // Scoreboard monitor: a transfer happens on the coming edge.
    always @(negedge clk) begin
        if (resetn && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_cmd: got 0x%04h required none", {cmd_reg, cmd_data});
            end else begin
                check("cmd", {16'h0, cmd_reg, cmd_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset();
        resetn    = 1'b0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nack_left[i] = 0;
            xfer_cnt[i]  = 0;
        end
        gaps.delete();
        stall_idx      = 0;
        stall_left     = 0;
        reset_in_stall = 1'b0;
        spurious       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", cmd_valid, 0);
        check("rst_reg", cmd_reg, 0);
        check("rst_data", cmd_data, 0);
        check("rst_done", init_done, 0);
        check("rst_error", init_error, 0);
        check("rst_index", cur_index, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("first_valid", cmd_valid, 1);
        check("first_cmd", {cmd_reg, cmd_data}, 16'h1280);
    endtask

    // Drives cmd_ready / rsp_valid / rsp_nack cycle by cycle. A response
    // is sampled by the DUT 3 edges after each transfer edge.
    task automatic run_seq(input int budget);
        int rsp_cnt     = 0;
        int pend_idx    = 0;
        bit pend        = 0;
        bit rsp_real    = 0;
        int rsp_edge    = -1;
        int cyc         = 0;
        int tail        = -1;
        int after_valid = 0;
        bit did_reset   = 0;
        bit stalling    = 0;
        bit prev_valid;
        prev_valid = cmd_valid;
        while (cyc < budget && tail != 0) begin
            @(posedge clk);
            #1;
            cyc++;
            if (did_reset) begin
                check("midrst_valid", cmd_valid, 0);
                check("midrst_index", cur_index, 0);
                resetn    = 1'b1;
                did_reset = 0;
                rsp_edge  = -1;
                rsp_cnt   = 0;
            end
            if (rsp_real) rsp_edge = cyc;
            rsp_real  = 0;
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            cmd_ready = 1'b1;

            if (pend) begin
                xfer_cnt[pend_idx]++;
                rsp_cnt = 2;
            end else if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_real  = 1;
                    if (nack_left[pend_idx] > 0) begin
                        rsp_nack = 1'b1;
                        nack_left[pend_idx]--;
                    end
                end
            end

            // Pulses in LOAD (right after a response), DELAY and SEND.
            if (spurious && resetn && rsp_cnt == 0 && !rsp_valid &&
                (rsp_edge == cyc || cmd_valid || (cur_index == 8'd1 && !cmd_valid))) begin
                rsp_valid = 1'b1;
                rsp_nack  = cmd_valid;
            end

            if (stall_left > 0 && cur_index == 8'(stall_idx) && (stalling || cmd_valid)) begin
                stalling  = 1;
                cmd_ready = 1'b0;
                stall_left--;
                check("stall_valid", cmd_valid, 1);
                check("stall_reg", cmd_reg, 8'h11);
                check("stall_data", cmd_data, 8'h01);
                if (stall_left == 0) stalling = 0;
                if (reset_in_stall && stall_left == 3) begin
                    resetn         = 1'b0;
                    did_reset      = 1;
                    stall_left     = 0;
                    stalling       = 0;
                    reset_in_stall = 1'b0;
                end
            end

            if (cmd_valid && !prev_valid && rsp_edge >= 0) gaps.push_back(cyc - rsp_edge);
            prev_valid = cmd_valid;

            pend = cmd_valid && cmd_ready && resetn;
            if (pend) pend_idx = int'(cur_index);

            if (tail > 0) begin
                tail--;
                if (cmd_valid) after_valid++;
            end else if (tail < 0 && (init_done || init_error)) begin
                tail = 20;
            end
        end
        check("finished_in_budget", (tail == 0), 1);
        check("valid_after_end", after_valid, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_gaps();
        int exp_gaps[4] = '{12, 1, 1, 1};
        check("gap_count", gaps.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gaps.size()) check("cmd_gap", gaps[i], exp_gaps[i]);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;

        // Baseline run, ready always high.
        do_reset();
        push_full();
        run_seq(2000);
        check("base_done", init_done, 1);
        check("base_error", init_error, 0);
        check("base_index", cur_index, 5);
        check("base_xfer3", xfer_cnt[3], 1);
        check_gaps();

        // Backpressure on index 3 plus spurious responses.
        do_reset();
        stall_idx  = 3;
        stall_left = 7;
        spurious   = 1'b1;
        push_full();
        run_seq(2000);
        check("bp_done", init_done, 1);
        check("bp_error", init_error, 0);
        check("bp_xfer3", xfer_cnt[3], 1);
        check_gaps();

        // One NACK on index 2.
        do_reset();
        nack_left[2] = 1;
        push(8'h12, 8'h80);
        push(8'h12, 8'h04);
        push(8'h12, 8'h04);
        push(8'h11, 8'h01);
        push(8'h40, 8'hD0);
        push(8'h3A, 8'h04);
        run_seq(2000);
        check("nack1_done", init_done, 1);
        check("nack1_error", init_error, 0);
        check("nack1_xfer2", xfer_cnt[2], 2);

        // NACK on every attempt at index 4.
        do_reset();
        nack_left[4] = 100;
        push(8'h12, 8'h80);
        push(8'h12, 8'h04);
        push(8'h11, 8'h01);
        for (int i = 0; i < 4; i++) push(8'h40, 8'hD0);
        run_seq(2000);
        check("abort_error", init_error, 1);
        check("abort_done", init_done, 0);
        check("abort_index", cur_index, 4);
        check("abort_xfer4", xfer_cnt[4], 4);
        check("abort_xfer5", xfer_cnt[5], 0);

        // Reset pulse while SEND holds index 3.
        do_reset();
        stall_idx      = 3;
        stall_left     = 6;
        reset_in_stall = 1'b1;
        push(8'h12, 8'h80);
        push(8'h12, 8'h04);
        push_full();
        run_seq(2000);
        check("midrst_done", init_done, 1);
        check("midrst_xfer0", xfer_cnt[0], 2);
        check("midrst_xfer3", xfer_cnt[3], 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
